// File: rtl/fetch_buffer_unit.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, instruction FIFO.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped saturating counters.
module fetch_buffer_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [31:0]     buf_instr [DEPTH];
    logic [XLEN-1:0] buf_pc    [DEPTH];
    logic [XLEN-1:0] pcq       [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW-1:0]   q_wr, q_rd;
    logic [CW-1:0]   count, outstanding, drop;

    logic [CW:0]     credit_sum;
    logic            rsp_ok, req_fire, push, pop, discard;

    always_comb begin
        credit_sum     = {1'b0, outstanding} + {1'b0, count};
        imem_req_valid = rst_n && !redirect_valid &&
                         (credit_sum < (CW+1)'(DEPTH));
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        // Responses with nothing outstanding are leftovers from before reset.
        rsp_ok         = imem_rsp_valid && (outstanding != '0);
        push           = rsp_ok && !redirect_valid && (drop == '0);
        discard        = rsp_ok && !push;
        id_valid       = (count != '0);
        pop            = id_valid && id_ready && !redirect_valid;
        id_instr       = buf_instr[rd_ptr];
        id_pc          = buf_pc[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
                pcq[i]       <= '0;
            end
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_ok);
            if (rsp_ok)
                q_rd <= q_rd + AW'(1);
            if (req_fire) begin
                pcq[q_wr] <= fetch_pc;
                q_wr      <= q_wr + AW'(1);
            end
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                // Everything still in flight belongs to the old path.
                drop     <= outstanding - CW'(rsp_ok);
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (push) begin
                    buf_instr[wr_ptr] <= imem_rsp_data;
                    buf_pc[wr_ptr]    <= pcq[q_rd];
                    wr_ptr            <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (rsp_ok && (drop != '0))
                    drop <= drop - CW'(1);
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (pop && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (discard && (perf_dropped != '1))
                perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_buffer_unit.md
Name: fetch_buffer_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage that hosts the immediate Extractor.
- Generates sequential fetch PCs and issues word requests to instruction memory over a valid/ready request channel.
- Buffers returned instruction words in a small FIFO and presents {instr, pc} to decode with valid/ready.
- Handles redirects (branch/jump/trap) by flushing the buffer and discarding stale in-flight responses.

Parameters:
- XLEN, 32, datapath/PC width (from riscv_pkg).
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- DEPTH, 2, instruction buffer entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous and active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in request order, always accepted, latency ≥1 cycle
- imem_rsp_data  in  32  fetched instruction word
- redirect_valid  in  1  PC redirect strobe from execute
- redirect_pc  in  XLEN  redirect target
- id_valid  out  1  instruction available to decode
- id_ready  in  1  decode accepts instruction
- id_instr  out  32  instruction word (drives Extractor Instr)
- id_pc  out  XLEN  PC of id_instr

Behaviour:
- Reset (rst_n=0 at clk edge):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0.
- Credit rule: imem_req_valid=1 iff outstanding + fifo_count < DEPTH and no redirect this cycle.
  - imem_req_addr=fetch_pc.
  - Request handshake (valid&&ready): fetch_pc += 4 (wraps modulo 2^XLEN); outstanding++.
- Response: imem_rsp_valid decrements outstanding in the same cycle.
  - drop>0: decrement drop, discard data.
  - drop=0: push {data, pc}. The pushed pc comes from a DEPTH-entry in-flight PC queue written on request handshake.
  - The credit rule guarantees a push never overflows.
- Decode side: id_valid = FIFO non-empty; id_instr/id_pc = head entry, combinational from storage. Pop on id_valid&&id_ready.
- Push and pop in the same cycle: count unchanged. Push into an empty FIFO becomes visible (id_valid=1) the next cycle; no bypass, minimum latency is response +1 cycle.
- Redirect (redirect_valid=1 at edge), which has priority over all other events in that cycle:
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - FIFO flushed; pop ignored.
  - drop = outstanding after this cycle's response accounting.
  - No request issued in the redirect cycle (imem_req_valid=0).
  - A response arriving in the redirect cycle is discarded.
- Back-to-back redirects: the last one wins; drop accumulates correctly.
- Full/stall: FIFO full and id_ready=0 → no requests; PC holds.
- Reset mid-operation: all state cleared; late memory responses after reset are ignored only if outstanding=0. The system guarantees memory is reset together with this block.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs perf_fetched (32, increments on each pop) and perf_dropped (32, increments on each discarded response). Both reset to 0, saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, RESET_PC=0, memory 1-cycle latency, id_ready=1 → requests 0x0,0x4,0x8,...; first id_valid 2 cycles after first request; id_pc follows request addresses, id_instr follows memory contents (e.g. 0xFFA9A383 at 0x0).
- id_ready=0 with DEPTH=2 → after 2 responses, imem_req_valid=0, fetch_pc holds at 0x8; raise id_ready → pops 0x0 then 0x4, fetching resumes at 0x8.
- 2 requests outstanding, redirect_valid with redirect_pc=0x1003 → next request addr 0x1000; both stale responses discarded; first id_pc=0x1000.
- Redirect coincident with a pop and a response → FIFO empty next cycle, no request that cycle, response dropped.
- imem_req_ready held low 5 cycles → imem_req_valid stays 1, address stable at 0x0, outstanding stays 0.
- FETCH_PERF_EN build, 4 delivered and 2 dropped → perf_fetched=4, perf_dropped=2; both 0 after rst_n=0.
